tmp_seq_ctrl: RTL and testbench

//  Parametrised multi-channel sequencer for the switched-cap temperature front end.
//  - Per selected channel: precharge, diode phase and big-diode phase with non-overlap blanking.
//  - Charge-balance feedback: comparator-driven H/L charge pulses between big-diode phases.
//  - Counts comparator-high decisions over a programmed number of cycles into a code.
//  - Emits one valid-flagged result per channel and steps round-robin over enabled sensors.

---
 rtl/tmp_seq_pkg.sv | 24 ++
 rtl/tmp_seq_sync.sv | 21 ++
 rtl/tmp_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_tmp_seq_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmp_seq_pkg.sv
// Shared types and constants for the switched-cap temperature sequencer.
package tmp_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRECHARGE,
    BLANK_D,
    DIODE,
    BLANK_B,
    BIGDIODE,
    HCHARGE,
    LCHARGE,
    OUTPUT
  } state_t;

  // {PA,PB,PC,PD} capacitor switch patterns
  localparam logic [3:0] PABCD_ALL = 4'b1111;
  localparam logic [3:0] PABCD_H   = 4'b1100;
  localparam logic [3:0] PABCD_L   = 4'b1010;
  localparam logic [3:0] PABCD_OFF = 4'b0000;

  localparam int PHW = 16;

endpackage

// File: rtl/tmp_seq_sync.sv
// Two-flop synchroniser for the asynchronous comparator output.
module tmp_seq_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tmp_seq_ctrl.sv
// Multi-channel switched-cap temperature sequencer with charge-balance counting.
// Optional per-channel result averaging is enabled by defining TMP_SEQ_AVG_EN.
module tmp_seq_ctrl
  import tmp_seq_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int PRE_CYC   = 2,
  parameter int BLANK_CYC = 1,
  parameter int DIODE_CYC = 1,
  parameter int BIG_CYC   = 2,
  parameter int SETUP_CYC = 20,
  parameter int CONV_CYC  = 8,
  localparam int CW       = $clog2(CONV_CYC * BIG_CYC + 1),
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic [NCH-1:0] ch_mask,
  input  logic           cmp,
  output logic           pre_chrg,
  output logic           pii1,
  output logic           pii2,
  output logic           pi1,
  output logic           pi2,
  output logic [3:0]     pabcd,
  output logic           src_n,
  output logic           snk,
  output logic [NCH-1:0] ch_sel,
  output logic           busy,
  output logic           valid,
  output logic [CW-1:0]  result,
  output logic [CHW-1:0] result_ch,
  output state_t         dbg_state
);

  localparam int NPAIR = SETUP_CYC + CONV_CYC;
  localparam int PCW   = $clog2(NPAIR + 1);
  localparam logic [CW-1:0] CODE_MAX = '1;

  state_t           state, state_nxt;
  logic [PHW-1:0]   phase_cnt;
  logic [PCW-1:0]   pair_cnt, pair_nxt;
  logic [CW-1:0]    code, res_new;
  logic [CHW-1:0]   cur_ch, last_ch, pick_ch;
  logic             pick_ok, cmp_s, phase_done;

  tmp_seq_sync u_sync (.clk(clk), .reset_n(reset_n), .d(cmp), .q(cmp_s));

  function automatic logic [PHW-1:0] phase_len(input state_t s);
    case (s)
      PRECHARGE:        phase_len = PHW'(PRE_CYC - 1);
      BLANK_D, BLANK_B: phase_len = PHW'(BLANK_CYC - 1);
      DIODE:            phase_len = PHW'(DIODE_CYC - 1);
      BIGDIODE:         phase_len = PHW'(BIG_CYC - 1);
      default:          phase_len = '0;
    endcase
  endfunction

  // Round-robin: nearest set mask bit after last_ch; offset NCH (last_ch itself) has lowest priority.
  always_comb begin
    pick_ok = 1'b0;
    pick_ch = last_ch;
    for (int i = NCH; i >= 1; i--) begin
      if (ch_mask[(int'(last_ch) + i) % NCH]) begin
        pick_ok = 1'b1;
        pick_ch = CHW'((int'(last_ch) + i) % NCH);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    phase_done = (phase_cnt == '0);
    pair_nxt   = pair_cnt + PCW'(1);
    pre_chrg   = 1'b0;
    pii1       = 1'b0;
    pii2       = 1'b0;
    pi1        = 1'b0;
    pi2        = 1'b0;
    pabcd      = PABCD_OFF;
    case (state)
      IDLE:      if (en && pick_ok) state_nxt = PRECHARGE;
      PRECHARGE: begin
        pre_chrg = 1'b1;
        pabcd    = PABCD_ALL;
        if (phase_done) state_nxt = BLANK_D;
      end
      BLANK_D:   if (phase_done) state_nxt = DIODE;
      DIODE: begin
        pii1 = 1'b1;
        pii2 = 1'b1;
        if (phase_done) state_nxt = BLANK_B;
      end
      BLANK_B:   if (phase_done) state_nxt = BIGDIODE;
      BIGDIODE: begin
        pi1 = 1'b1;
        pi2 = 1'b1;
        if (phase_done) state_nxt = cmp_s ? HCHARGE : LCHARGE;
      end
      HCHARGE, LCHARGE: begin
        pabcd     = (state == HCHARGE) ? PABCD_H : PABCD_L;
        state_nxt = (pair_nxt < PCW'(NPAIR)) ? BLANK_D : OUTPUT;
      end
      OUTPUT: begin
        pabcd     = PABCD_ALL;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

`ifdef TMP_SEQ_AVG_EN
  logic [CW-1:0]  avg [NCH];
  logic [NCH-1:0] avg_seen;
  logic [CW+1:0]  avg_sum;

  always_comb begin
    avg_sum = {1'b0, avg[cur_ch], 1'b0} + {2'b00, avg[cur_ch]} + {2'b00, code} + (CW+2)'(2);
    res_new = avg_seen[cur_ch] ? avg_sum[CW+1:2] : code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) avg[i] <= '0;
      avg_seen <= '0;
    end else if ((state == HCHARGE || state == LCHARGE) && state_nxt == OUTPUT) begin
      avg[cur_ch]      <= res_new;
      avg_seen[cur_ch] <= 1'b1;
    end
  end
`else
  assign res_new = code;
`endif

  // valid is a one-cycle strobe coinciding with OUTPUT; result/result_ch are stable while it is high
  // and hold until the next strobe. There is no back-pressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      pair_cnt  <= '0;
      code      <= '0;
      cur_ch    <= '0;
      last_ch   <= CHW'(NCH - 1);
      ch_sel    <= '0;
      src_n     <= 1'b1;
      snk       <= 1'b0;
      valid     <= 1'b0;
      result    <= '0;
      result_ch <= '0;
    end else begin
      state <= state_nxt;
      valid <= 1'b0;
      if (state_nxt != state) phase_cnt <= phase_len(state_nxt);
      else if (!phase_done)   phase_cnt <= phase_cnt - PHW'(1);
      case (state)
        IDLE: if (state_nxt == PRECHARGE) begin
          cur_ch  <= pick_ch;
          last_ch <= pick_ch;
          ch_sel  <= NCH'(1) << pick_ch;
        end
        PRECHARGE: begin
          pair_cnt <= '0;
          code     <= '0;
        end
        BIGDIODE: begin
          if (cmp_s) src_n <= ~src_n;
          else       snk   <= ~snk;
          if (cmp_s && pair_cnt >= PCW'(SETUP_CYC) && code != CODE_MAX) code <= code + CW'(1);
        end
        HCHARGE, LCHARGE: begin
          pair_cnt <= pair_nxt;
          if (state_nxt == OUTPUT) begin
            valid     <= 1'b1;
            result    <= res_new;
            result_ch <= cur_ch;
          end
        end
        OUTPUT: begin
          src_n  <= 1'b1;
          snk    <= 1'b0;
          ch_sel <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_tmp_seq_ctrl.sv
// Scoreboard bench for tmp_seq_ctrl: directed conversions, phase/non-overlap monitor, reset mid-run.
module tb_tmp_seq_ctrl;
  import tmp_seq_pkg::*;

  localparam int NCH = 4, BIG = 2, SETUP = 20, CONV = 8;
  localparam int CW = 5, CHW = 2, W = CHW + CW;

  logic clk = 1'b0, reset_n = 1'b0, en = 1'b0, cmp = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic pre_chrg, pii1, pii2, pi1, pi2, src_n, snk, busy, valid;
  logic [3:0] pabcd;
  logic [NCH-1:0] ch_sel;
  logic [CW-1:0] result;
  logic [CHW-1:0] result_ch;
  state_t dbg_state;

  int n_tests = 0, n_fail = 0, n_valid = 0;
  int grp_viol = 0, snk_tog = 0, src_low = 0, cmp_mode = 0;
  logic [W-1:0] exp_q[$];
  logic s1 = 1'b0, s2 = 1'b0, last_cs = 1'b0, prev_snk = 1'b0;
  logic [2:0] prev_grp = '0;
  logic [CW-1:0] m_avg [NCH];
  logic [NCH-1:0] m_seen = '0;

  // clock / reset
  always #5 clk = ~clk;

  tmp_seq_ctrl #(.NCH(NCH), .PRE_CYC(2), .BLANK_CYC(1), .DIODE_CYC(1), .BIG_CYC(BIG),
                 .SETUP_CYC(SETUP), .CONV_CYC(CONV)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .ch_mask(ch_mask), .cmp(cmp),
    .pre_chrg(pre_chrg), .pii1(pii1), .pii2(pii2), .pi1(pi1), .pi2(pi2), .pabcd(pabcd),
    .src_n(src_n), .snk(snk), .ch_sel(ch_sel), .busy(busy), .valid(valid),
    .result(result), .result_ch(result_ch), .dbg_state(dbg_state));

  // reference for what the DUT sees as cmp_s in each cycle
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= cmp;
      s2 <= s1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  initial begin
    forever begin
      @(negedge clk);
      case (cmp_mode)
        0:       cmp = 1'b0;
        1:       cmp = 1'b1;
        default: cmp = ~cmp;
      endcase
    end
  end

  function automatic void push_exp(input int ch, input int code);
    logic [CW-1:0] r;
    r = CW'(code);
`ifdef TMP_SEQ_AVG_EN
    if (m_seen[ch]) r = CW'((3 * int'(m_avg[ch]) + code + 2) >> 2);
    m_avg[ch]  = r;
    m_seen[ch] = 1'b1;
`endif
    exp_q.push_back({CHW'(ch), r});
  endfunction

  task automatic wait_busy(input logic val);
    int t = 0;
    while (busy !== val && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (busy !== val) check("busy_timeout", 32'(busy), 32'(val));
  endtask

  task automatic run(input logic [NCH-1:0] mask, input int n);
    ch_mask = mask;
    en = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_busy(1'b1);
      if (k == n - 1) en = 1'b0;
      wait_busy(1'b0);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pre_chrg"}, 32'(pre_chrg), 0);
    check({tag, "_pii"}, {30'd0, pii1, pii2}, 0);
    check({tag, "_pi"}, {30'd0, pi1, pi2}, 0);
    check({tag, "_pabcd"}, 32'(pabcd), 0);
    check({tag, "_src_n"}, 32'(src_n), 1);
    check({tag, "_snk"}, 32'(snk), 0);
    check({tag, "_ch_sel"}, 32'(ch_sel), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_result_ch"}, 32'(result_ch), 0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [2:0] grp;
    logic [W-1:0] e;
    grp = {pre_chrg, pii1 | pii2, pi1 | pi2};
    if ($countones(grp) > 1) grp_viol++;
    if (pii1 != pii2 || pi1 != pi2) grp_viol++;
    if (grp != 0 && prev_grp != 0 && grp != prev_grp) grp_viol++;
    prev_grp = grp;
    if (snk != prev_snk) snk_tog++;
    prev_snk = snk;
    if (!src_n) src_low++;
    if (dbg_state == BIGDIODE) last_cs = s2;
    if (dbg_state == HCHARGE || dbg_state == LCHARGE) begin
      check("hl_follows_cmp", 32'(dbg_state == HCHARGE), 32'(last_cs));
      check("hl_pabcd", 32'(pabcd), last_cs ? 32'(PABCD_H) : 32'(PABCD_L));
    end
    if (valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got ch %0d code %0d expected none", result_ch, result);
      end else begin
        e = exp_q.pop_front();
        check("result_code", 32'(result), 32'(e[CW-1:0]));
        check("result_ch", 32'(result_ch), 32'(e[W-1:CW]));
        check("ch_sel", 32'(ch_sel), 32'(1) << e[W-1:CW]);
      end
    end
  end

  initial begin
    int busy_seen, v0, t;
    for (int i = 0; i < NCH; i++) m_avg[i] = '0;
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("after_reset");

    // cmp high: full count on ch 0
    cmp_mode = 1;
    repeat (5) @(negedge clk);
    push_exp(0, CONV * BIG);
    push_exp(0, CONV * BIG);
    run(4'b0001, 2);

    // cmp low: zero code, sink toggles every big-diode cycle, source untouched
    cmp_mode = 0;
    repeat (5) @(negedge clk);
    snk_tog = 0;
    src_low = 0;
    push_exp(0, 0);
    run(4'b0001, 1);
    check("snk_toggles", 32'(snk_tog), 32'((SETUP + CONV) * BIG));
    check("src_n_low_cycles", 32'(src_low), 0);

    // alternating cmp: half code
    cmp_mode = 2;
    repeat (5) @(negedge clk);
    push_exp(0, CONV);
    run(4'b0001, 1);

    // round-robin over channels 1 and 3
    cmp_mode = 1;
    repeat (5) @(negedge clk);
    push_exp(1, 16);
    push_exp(3, 16);
    push_exp(1, 16);
    push_exp(3, 16);
    run(4'b1010, 4);

    // empty mask never starts
    ch_mask = '0;
    en = 1'b1;
    busy_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("mask0_busy", 32'(busy_seen), 0);
    en = 1'b0;

    // reset in the middle of the second channel's big-diode phase
    push_exp(0, 16);
    v0 = n_valid;
    ch_mask = 4'b0111;
    en = 1'b1;
    t = 0;
    while (n_valid == v0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("rst_first_valid", 32'(n_valid), 32'(v0 + 1));
    t = 0;
    while (dbg_state != BIGDIODE && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("rst_reach_big", 32'(dbg_state), 32'(BIGDIODE));
    reset_n = 1'b0;
    en = 1'b0;
    #1;
    check_idle("mid_reset");
    m_seen = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    push_exp(0, 16);
    run(4'b0111, 1);

`ifdef TMP_SEQ_AVG_EN
    cmp_mode = 0;
    repeat (5) @(negedge clk);
    push_exp(0, 0);
    push_exp(0, 0);
    push_exp(0, 0);
    run(4'b0001, 3);
`endif

    repeat (10) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    check("non_overlap_violations", 32'(grp_viol), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
